// File: rtl/draw_scheduler_if.sv
// Drawer-to-scheduler bus: per-drawer pixel/done inputs, one-hot grant and the muxed VGA write port.
interface draw_scheduler_if #(
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7,
    parameter int unsigned C_W = 3
);
    logic           erase_done;
    logic           bird_done;
    logic           wall_done;
    logic [X_W-1:0] erase_x;
    logic [X_W-1:0] bird_x;
    logic [X_W-1:0] wall_x;
    logic [Y_W-1:0] erase_y;
    logic [Y_W-1:0] bird_y;
    logic [Y_W-1:0] wall_y;
    logic [C_W-1:0] erase_colour;
    logic [C_W-1:0] bird_colour;
    logic [C_W-1:0] wall_colour;
    logic           erase_plot;
    logic           bird_plot;
    logic           wall_plot;
    logic [2:0]     gnt;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic           vga_plot;

    // Drawer/environment side
    modport master (
        output erase_done, bird_done, wall_done,
        output erase_x, bird_x, wall_x,
        output erase_y, bird_y, wall_y,
        output erase_colour, bird_colour, wall_colour,
        output erase_plot, bird_plot, wall_plot,
        input  gnt, vga_x, vga_y, vga_colour, vga_plot
    );

    // Scheduler side
    modport slave (
        input  erase_done, bird_done, wall_done,
        input  erase_x, bird_x, wall_x,
        input  erase_y, bird_y, wall_y,
        input  erase_colour, bird_colour, wall_colour,
        input  erase_plot, bird_plot, wall_plot,
        output gnt, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sequencer (erase, update, bird, wall) and arbiter for the single VGA write port.
// Also tracks game-over on collision, dropped frame ticks and per-phase watchdog expiries.
module draw_scheduler #(
    parameter int unsigned     X_W     = 8,
    parameter int unsigned     Y_W     = 7,
    parameter int unsigned     C_W     = 3,
    parameter int unsigned     TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd32768
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go_n,
    input  logic               frame_tick,
    input  logic               collision,
    draw_scheduler_if.slave    bus,
    output logic               update_pulse,
    output logic               game_over,
    output logic [2:0]         cur_state,
    output logic [7:0]         overrun_count,
    output logic               timeout_err
);
    localparam int unsigned     OVR_W   = 8;
    localparam logic [TO_W-1:0] WD_LAST = TIMEOUT - TO_W'(1);
    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_IDLE   = 3'd1,
        S_ERASE  = 3'd2,
        S_UPDATE = 3'd3,
        S_BIRD   = 3'd4,
        S_WALL   = 3'd5,
        S_DEAD   = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt_c;
    logic             go_q;
    logic [TO_W-1:0]  wd_cnt;
    logic             press_c;
    logic             in_phase_c;
    logic             phase_done_c;
    logic             timeout_c;
    logic             tick_drop_c;
    logic [2:0]       gnt_nxt_c;

    assign cur_state = 3'(state);

    // Phase status: which done counts for the current phase and whether the watchdog expires
    always_comb begin
        press_c      = go_q & ~go_n;
        in_phase_c   = 1'b0;
        phase_done_c = 1'b0;
        tick_drop_c  = 1'b0;
        case (state)
            S_ERASE: begin
                in_phase_c   = 1'b1;
                phase_done_c = bus.erase_done;
                tick_drop_c  = frame_tick;
            end
            S_UPDATE: begin
                tick_drop_c  = frame_tick;
            end
            S_BIRD: begin
                in_phase_c   = 1'b1;
                phase_done_c = bus.bird_done;
                tick_drop_c  = frame_tick;
            end
            S_WALL: begin
                in_phase_c   = 1'b1;
                phase_done_c = bus.wall_done;
                tick_drop_c  = frame_tick;
            end
            default: ;
        endcase
        // A done in the expiry cycle wins, so the error flag stays clear
        timeout_c = in_phase_c & ~phase_done_c & (wd_cnt == WD_LAST);
    end

    // Next-state and next-grant decode
    always_comb begin
        state_nxt_c = state;
        case (state)
            S_START:  if (press_c) state_nxt_c = S_IDLE;
            S_IDLE:   if (frame_tick) state_nxt_c = S_ERASE;
            S_ERASE:  if (phase_done_c || timeout_c) state_nxt_c = S_UPDATE;
            S_UPDATE: state_nxt_c = S_BIRD;
            S_BIRD:   if (phase_done_c || timeout_c) state_nxt_c = S_WALL;
            S_WALL:   if (phase_done_c || timeout_c) state_nxt_c = collision ? S_DEAD : S_IDLE;
            S_DEAD:   if (press_c) state_nxt_c = S_IDLE;
            default:  state_nxt_c = S_START;
        endcase

        gnt_nxt_c = 3'b000;
        case (state_nxt_c)
            S_ERASE: gnt_nxt_c = 3'b001;
            S_BIRD:  gnt_nxt_c = 3'b010;
            S_WALL:  gnt_nxt_c = 3'b100;
            default: gnt_nxt_c = 3'b000;
        endcase
    end

    // State register with Moore outputs registered alongside the state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_START;
            go_q          <= 1'b1;
            bus.gnt       <= 3'b000;
            update_pulse  <= 1'b0;
            game_over     <= 1'b0;
            wd_cnt        <= '0;
            timeout_err   <= 1'b0;
            overrun_count <= '0;
        end else begin
            state        <= state_nxt_c;
            go_q         <= go_n;
            bus.gnt      <= gnt_nxt_c;
            update_pulse <= (state_nxt_c == S_UPDATE);
            game_over    <= (state_nxt_c == S_DEAD);

            if (state_nxt_c != state) begin
                wd_cnt <= '0;
            end else if (in_phase_c) begin
                wd_cnt <= wd_cnt + TO_W'(1);
            end

            if (timeout_c) begin
                timeout_err <= 1'b1;
            end

            if (tick_drop_c && (overrun_count != OVR_MAX)) begin
                overrun_count <= overrun_count + OVR_W'(1);
            end
        end
    end

    // VGA port: one-cycle registered copy of the granted drawer; coordinates hold when idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
        end else begin
            bus.vga_plot <= 1'b0;
            if (bus.gnt[0]) begin
                bus.vga_x      <= bus.erase_x;
                bus.vga_y      <= bus.erase_y;
                bus.vga_colour <= bus.erase_colour;
                bus.vga_plot   <= bus.erase_plot;
            end else if (bus.gnt[1]) begin
                bus.vga_x      <= bus.bird_x;
                bus.vga_y      <= bus.bird_y;
                bus.vga_colour <= bus.bird_colour;
                bus.vga_plot   <= bus.bird_plot;
            end else if (bus.gnt[2]) begin
                bus.vga_x      <= bus.wall_x;
                bus.vga_y      <= bus.wall_y;
                bus.vga_colour <= bus.wall_colour;
                bus.vga_plot   <= bus.wall_plot;
            end
        end
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: two instances (long and 16-cycle watchdog) share stimulus.
module tb_draw_scheduler;
    localparam int unsigned X_W  = 8;
    localparam int unsigned Y_W  = 7;
    localparam int unsigned C_W  = 3;
    localparam int unsigned TO_W = 16;

    logic clk = 1'b0;
    logic resetn;
    logic go_n;
    logic frame_tick;
    logic collision;

    logic       up_a, go_a, te_a, up_b, go_b, te_b;
    logic [2:0] st_a, st_b;
    logic [7:0] ovr_a, ovr_b;

    int checks = 0;
    int errors = 0;
    int exp_ovr = 0;

    initial forever #5 clk = ~clk;

    draw_scheduler_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) ifa ();
    draw_scheduler_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) ifb ();

    assign ifb.erase_done   = ifa.erase_done;
    assign ifb.bird_done    = ifa.bird_done;
    assign ifb.wall_done    = ifa.wall_done;
    assign ifb.erase_x      = ifa.erase_x;
    assign ifb.bird_x       = ifa.bird_x;
    assign ifb.wall_x       = ifa.wall_x;
    assign ifb.erase_y      = ifa.erase_y;
    assign ifb.bird_y       = ifa.bird_y;
    assign ifb.wall_y       = ifa.wall_y;
    assign ifb.erase_colour = ifa.erase_colour;
    assign ifb.bird_colour  = ifa.bird_colour;
    assign ifb.wall_colour  = ifa.wall_colour;
    assign ifb.erase_plot   = ifa.erase_plot;
    assign ifb.bird_plot    = ifa.bird_plot;
    assign ifb.wall_plot    = ifa.wall_plot;

    draw_scheduler #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TO_W(TO_W), .TIMEOUT(16'd32768)) dut_a (
        .clk(clk), .resetn(resetn), .go_n(go_n), .frame_tick(frame_tick), .collision(collision),
        .bus(ifa.slave), .update_pulse(up_a), .game_over(go_a), .cur_state(st_a),
        .overrun_count(ovr_a), .timeout_err(te_a)
    );

    draw_scheduler #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TO_W(TO_W), .TIMEOUT(16'd16)) dut_b (
        .clk(clk), .resetn(resetn), .go_n(go_n), .frame_tick(frame_tick), .collision(collision),
        .bus(ifb.slave), .update_pulse(up_b), .game_over(go_b), .cur_state(st_b),
        .overrun_count(ovr_b), .timeout_err(te_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_drawers();
        ifa.erase_done = 1'b0; ifa.bird_done = 1'b0; ifa.wall_done = 1'b0;
        ifa.erase_plot = 1'b0; ifa.bird_plot = 1'b0; ifa.wall_plot = 1'b0;
        ifa.erase_x = '0; ifa.bird_x = '0; ifa.wall_x = '0;
        ifa.erase_y = '0; ifa.bird_y = '0; ifa.wall_y = '0;
        ifa.erase_colour = '0; ifa.bird_colour = '0; ifa.wall_colour = '0;
    endtask

    task automatic rand_pixels();
        ifa.erase_x = X_W'($urandom); ifa.bird_x = X_W'($urandom); ifa.wall_x = X_W'($urandom);
        ifa.erase_y = Y_W'($urandom); ifa.bird_y = Y_W'($urandom); ifa.wall_y = Y_W'($urandom);
        ifa.erase_colour = C_W'($urandom); ifa.bird_colour = C_W'($urandom);
        ifa.wall_colour = C_W'($urandom);
        ifa.erase_plot = 1'($urandom); ifa.bird_plot = 1'($urandom); ifa.wall_plot = 1'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0; go_n = 1'b1; frame_tick = 1'b0; collision = 1'b0;
        clear_drawers();
        step();
        step();
        resetn = 1'b1;
        exp_ovr = 0;
    endtask

    task automatic press();
        go_n = 1'b0;
        step();
        go_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0; go_n = 1'b0; frame_tick = 1'b0; collision = 1'b0;
        clear_drawers();
        #2;
        checks++; if (st_a !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st_a); end
        checks++; if (ifa.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", ifa.gnt); end
        checks++; if ({ifa.vga_plot, ifa.vga_x, ifa.vga_y, ifa.vga_colour} !== '0) begin
            errors++; $display("FAIL reset_vga: got %b expected 0", {ifa.vga_plot, ifa.vga_x, ifa.vga_y, ifa.vga_colour}); end
        checks++; if ({up_a, go_a, te_a, ovr_a} !== 11'd0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0", {up_a, go_a, te_a, ovr_a}); end
        step();
        resetn = 1'b1;
        // Key held through reset: edge register starts at 1, so the first clock sees a press
        step();
        checks++; if (st_a !== 3'd1) begin errors++; $display("FAIL reset_held_key_press: got %0d expected 1", st_a); end
        go_n = 1'b1;
        step();
    endtask

    task automatic test_start();
        do_reset();
        step();
        checks++; if (st_a !== 3'd0) begin errors++; $display("FAIL start_wait: got %0d expected 0", st_a); end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++; if (st_a !== 3'd0) begin errors++; $display("FAIL start_tick_ignored: got %0d expected 0", st_a); end
        go_n = 1'b0;
        step();
        go_n = 1'b1;
        checks++; if (st_a !== 3'd1) begin errors++; $display("FAIL start_press: got %0d expected 1", st_a); end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++; if (st_a !== 3'd2) begin errors++; $display("FAIL start_erase: got %0d expected 2", st_a); end
        checks++; if (ifa.gnt !== 3'b001) begin errors++; $display("FAIL start_gnt: got %b expected 001", ifa.gnt); end
        checks++; if (ovr_a !== 8'd0) begin errors++; $display("FAIL start_overrun: got %0d expected 0", ovr_a); end
    endtask

    // Entered in ERASE; walks a whole frame checking the VGA port against the granted drawer
    task automatic test_vga_mux();
        int ph_grant [5];
        int ph_len   [5];
        logic [X_W-1:0] ex;
        logic [Y_W-1:0] ey;
        logic [C_W-1:0] ec;
        logic           ep;
        ifa.erase_plot = 1'b1; ifa.erase_x = 8'd37; ifa.erase_y = 7'd12; ifa.erase_colour = 3'b101;
        ifa.bird_plot = 1'b1; ifa.bird_x = 8'd200; ifa.bird_y = 7'd99; ifa.bird_colour = 3'b010;
        ifa.wall_plot = 1'b1;
        step();
        checks++; if ({ifa.vga_plot, ifa.vga_x, ifa.vga_y, ifa.vga_colour} !== {1'b1, 8'd37, 7'd12, 3'd5}) begin
            errors++; $display("FAIL vga_fixed: got %0d/%0d/%0d/%0d expected 1/37/12/5",
                               ifa.vga_plot, ifa.vga_x, ifa.vga_y, ifa.vga_colour); end
        ex = 8'd37; ey = 7'd12; ec = 3'd5;
        ph_grant = '{1, 0, 2, 3, 0};
        ph_len   = '{$urandom_range(3, 12), 1, $urandom_range(2, 12), $urandom_range(2, 12), 3};
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                rand_pixels();
                if (c == ph_len[p] - 1) begin
                    if (ph_grant[p] == 1) ifa.erase_done = 1'b1;
                    if (ph_grant[p] == 2) ifa.bird_done = 1'b1;
                    if (ph_grant[p] == 3) ifa.wall_done = 1'b1;
                end
                ep = 1'b0;
                case (ph_grant[p])
                    1: begin ex = ifa.erase_x; ey = ifa.erase_y; ec = ifa.erase_colour; ep = ifa.erase_plot; end
                    2: begin ex = ifa.bird_x; ey = ifa.bird_y; ec = ifa.bird_colour; ep = ifa.bird_plot; end
                    3: begin ex = ifa.wall_x; ey = ifa.wall_y; ec = ifa.wall_colour; ep = ifa.wall_plot; end
                    default: ;
                endcase
                step();
                ifa.erase_done = 1'b0; ifa.bird_done = 1'b0; ifa.wall_done = 1'b0;
                checks++;
                if ({ifa.vga_plot, ifa.vga_x, ifa.vga_y, ifa.vga_colour} !== {ep, ex, ey, ec}) begin
                    errors++; $display("FAIL vga_mux phase%0d cyc%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                        p, c, ifa.vga_plot, ifa.vga_x, ifa.vga_y, ifa.vga_colour, ep, ex, ey, ec);
                end
            end
        end
        clear_drawers();
        checks++; if (st_a !== 3'd1) begin errors++; $display("FAIL vga_end_state: got %0d expected 1", st_a); end
    endtask

    // One frame from IDLE with done pulses at the given cycle of each phase
    task automatic run_frame(input int de, input int db, input int dw, input bit coll, input bit stray);
        int ups;
        logic [2:0] es;
        ups = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        ups += int'(up_a);
        checks++; if ({st_a, ifa.gnt} !== {3'd2, 3'b001}) begin
            errors++; $display("FAIL frame_erase_entry: got %0d/%b expected 2/001", st_a, ifa.gnt); end
        for (int i = 1; i < de; i++) begin
            if (stray && i == 1) begin
                ifa.bird_done = 1'b1; ifa.wall_done = 1'b1; go_n = 1'b0; frame_tick = 1'b1;
                exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
            end
            collision = 1'($urandom);
            step();
            ifa.bird_done = 1'b0; ifa.wall_done = 1'b0; go_n = 1'b1; frame_tick = 1'b0;
            ups += int'(up_a);
            checks++; if (st_a !== 3'd2) begin errors++; $display("FAIL frame_erase_hold: got %0d expected 2", st_a); end
        end
        ifa.erase_done = 1'b1;
        step();
        ifa.erase_done = 1'b0;
        ups += int'(up_a);
        checks++; if ({st_a, ifa.gnt, up_a} !== {3'd3, 3'b000, 1'b1}) begin
            errors++; $display("FAIL frame_update: got %0d/%b/%b expected 3/000/1", st_a, ifa.gnt, up_a); end
        step();
        ups += int'(up_a);
        checks++; if ({st_a, ifa.gnt} !== {3'd4, 3'b010}) begin
            errors++; $display("FAIL frame_bird_entry: got %0d/%b expected 4/010", st_a, ifa.gnt); end
        for (int i = 1; i < db; i++) begin
            if (stray && i == 1) begin
                ifa.erase_done = 1'b1; ifa.wall_done = 1'b1; frame_tick = 1'b1;
                exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
            end
            step();
            ifa.erase_done = 1'b0; ifa.wall_done = 1'b0; frame_tick = 1'b0;
            ups += int'(up_a);
            checks++; if (st_a !== 3'd4) begin errors++; $display("FAIL frame_bird_hold: got %0d expected 4", st_a); end
        end
        ifa.bird_done = 1'b1;
        step();
        ifa.bird_done = 1'b0;
        ups += int'(up_a);
        checks++; if ({st_a, ifa.gnt} !== {3'd5, 3'b100}) begin
            errors++; $display("FAIL frame_wall_entry: got %0d/%b expected 5/100", st_a, ifa.gnt); end
        for (int i = 1; i < dw; i++) begin
            if (stray && i == 1) begin ifa.erase_done = 1'b1; ifa.bird_done = 1'b1; end
            collision = 1'($urandom);
            step();
            ifa.erase_done = 1'b0; ifa.bird_done = 1'b0;
            ups += int'(up_a);
            checks++; if (st_a !== 3'd5) begin errors++; $display("FAIL frame_wall_hold: got %0d expected 5", st_a); end
        end
        collision = coll;
        ifa.wall_done = 1'b1;
        step();
        ifa.wall_done = 1'b0;
        collision = 1'b0;
        ups += int'(up_a);
        es = coll ? 3'd6 : 3'd1;
        checks++; if ({st_a, ifa.gnt, go_a} !== {es, 3'b000, coll}) begin
            errors++; $display("FAIL frame_end: got %0d/%b/%b expected %0d/000/%b", st_a, ifa.gnt, go_a, es, coll); end
        checks++; if (ups != 1) begin errors++; $display("FAIL frame_update_count: got %0d expected 1", ups); end
        checks++; if (ovr_a !== 8'(exp_ovr)) begin errors++; $display("FAIL frame_overrun: got %0d expected %0d", ovr_a, exp_ovr); end
    endtask

    task automatic test_frame();
        run_frame(10, 20, 5, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_frame($urandom_range(2, 15), $urandom_range(2, 15), $urandom_range(2, 15), 1'b0, 1'b1);
        end
    endtask

    task automatic test_dead();
        run_frame($urandom_range(2, 8), $urandom_range(2, 8), $urandom_range(2, 8), 1'b1, 1'b1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        checks++; if ({st_a, ifa.gnt, go_a} !== {3'd6, 3'b000, 1'b1}) begin
            errors++; $display("FAIL dead_tick_ignored: got %0d/%b/%b expected 6/000/1", st_a, ifa.gnt, go_a); end
        checks++; if (ovr_a !== 8'(exp_ovr)) begin errors++; $display("FAIL dead_overrun: got %0d expected %0d", ovr_a, exp_ovr); end
        go_n = 1'b0;
        step();
        go_n = 1'b1;
        checks++; if ({st_a, go_a} !== {3'd1, 1'b0}) begin
            errors++; $display("FAIL dead_restart: got %0d/%b expected 1/0", st_a, go_a); end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        press();
        for (int k = 0; k < 5; k++) begin
            run_frame($urandom_range(2, 6), $urandom_range(2, 6), $urandom_range(2, 6), 1'b0, 1'($urandom));
        end
    endtask

    // Runs on the 16-cycle watchdog instance
    task automatic test_timeout();
        int n;
        do_reset();
        press();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int i = 1; i < 16; i++) step();
        ifa.erase_done = 1'b1;
        step();
        ifa.erase_done = 1'b0;
        checks++; if ({st_b, te_b} !== {3'd3, 1'b0}) begin
            errors++; $display("FAIL timeout_done_wins: got %0d/%b expected 3/0", st_b, te_b); end
        step();
        checks++; if (st_b !== 3'd4) begin errors++; $display("FAIL timeout_bird_entry: got %0d expected 4", st_b); end
        n = 0;
        while (st_b !== 3'd5 && n < 100) begin
            step();
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL timeout_bird_cycles: got %0d expected 16", n); end
        checks++; if ({te_b, ifb.gnt} !== {1'b1, 3'b100}) begin
            errors++; $display("FAIL timeout_err_set: got %b/%b expected 1/100", te_b, ifb.gnt); end
        ifa.wall_done = 1'b1;
        step();
        ifa.wall_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0;
            step(); ifa.erase_done = 1'b1; step(); ifa.erase_done = 1'b0;
            step(); step(); ifa.bird_done = 1'b1; step(); ifa.bird_done = 1'b0;
            step(); ifa.wall_done = 1'b1; step(); ifa.wall_done = 1'b0;
            checks++; if ({st_b, te_b} !== {3'd1, 1'b1}) begin
                errors++; $display("FAIL timeout_sticky: got %0d/%b expected 1/1", st_b, te_b); end
        end
        do_reset();
        checks++; if (te_b !== 1'b0) begin errors++; $display("FAIL timeout_reset_clear: got %b expected 0", te_b); end
    endtask

    task automatic test_overrun();
        do_reset();
        press();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        ifa.erase_plot = 1'b1;
        ifa.erase_x = X_W'($urandom);
        for (int i = 0; i < 300; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if ($urandom_range(0, 1) == 1) step();
            exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
            if (i == 99) begin
                checks++; if (ovr_a !== 8'(exp_ovr)) begin
                    errors++; $display("FAIL overrun_mid: got %0d expected %0d", ovr_a, exp_ovr); end
            end
        end
        checks++; if ({st_a, ovr_a} !== {3'd2, 8'd255}) begin
            errors++; $display("FAIL overrun_saturate: got %0d/%0d expected 2/255", st_a, ovr_a); end
        checks++; if (ifa.vga_plot !== 1'b1) begin errors++; $display("FAIL overrun_plot_active: got %b expected 1", ifa.vga_plot); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({ifa.gnt, ifa.vga_plot, st_a, ovr_a} !== 15'd0) begin
            errors++; $display("FAIL async_reset: got gnt=%b plot=%b st=%0d ovr=%0d expected 000/0/0/0",
                               ifa.gnt, ifa.vga_plot, st_a, ovr_a); end
        step();
        resetn = 1'b1;
        clear_drawers();
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        go_n = 1'b1;
        frame_tick = 1'b0;
        collision = 1'b0;
        clear_drawers();
        test_reset();
        test_start();
        test_vga_mux();
        test_frame();
        test_dead();
        test_back_to_back();
        test_timeout();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Per-frame sequencer and VGA plot-port arbiter for the game.
- Shares the single VGA adapter write port between three drawers: background erase, bird and wall.
- Each frame it runs erase, a one-cycle object update pulse, the bird draw, then the wall draw.
- Watches collision to enter a game-over state, and restarts on a go key press.

Parameters:
X_W, 8, VGA x coordinate width
Y_W, 7, VGA y coordinate width
C_W, 3, colour width
TO_W, 16, width of the per-phase watchdog counter
TIMEOUT, 16'd32768, cycles allowed per draw phase before forced advance

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
go_n  in  1  active-low start key (level); a falling edge is a press
frame_tick  in  1  one-cycle pulse at frame start
collision  in  1  level from game logic, bird overlaps wall/ground
erase_done, bird_done, wall_done  in  1 each  one-cycle done pulse from each drawer
erase_x/bird_x/wall_x  in  X_W each  drawer pixel x
erase_y/bird_y/wall_y  in  Y_W each  drawer pixel y
erase_colour/bird_colour/wall_colour  in  C_W each  drawer pixel colour
erase_plot/bird_plot/wall_plot  in  1 each  drawer write strobe
gnt  out  3  one-hot grant: bit0 erase, bit1 bird, bit2 wall
update_pulse  out  1  one-cycle pulse telling game logic to advance positions
vga_x, vga_y, vga_colour, vga_plot  out  X_W/Y_W/C_W/1  registered muxed VGA write port
game_over  out  1  high in DEAD
cur_state  out  3  state encoding, for LEDs
overrun_count  out  8  frame_ticks dropped while busy, saturating
timeout_err  out  1  sticky: some phase hit TIMEOUT

Behaviour:
- Reset (async, resetn=0):
  - State START; all outputs 0.
  - go_n edge register loads 1.
  - Watchdog counter clears to 0.
- State encoding: START=0, IDLE=1, ERASE=2, UPDATE=3, BIRD=4, WALL=5, DEAD=6.
- Press detection: go_n registered each clk. A press is registered value 1 and current go_n 0.
- Transitions:
  - START: on press -> IDLE.
  - IDLE: on frame_tick -> ERASE.
  - ERASE: gnt=001. On erase_done or timeout -> UPDATE.
  - UPDATE: exactly one cycle; update_pulse=1, gnt=000. Then -> BIRD.
  - BIRD: gnt=010. On bird_done or timeout -> WALL.
  - WALL: gnt=100. On wall_done or timeout: if collision=1 that cycle -> DEAD, else -> IDLE.
  - DEAD: gnt=000, game_over=1. On press -> IDLE; game_over clears in the cycle IDLE is entered.
- gnt and update_pulse are registered and change in the cycle the state changes.
- Watchdog:
  - Cleared on entry to ERASE, BIRD and WALL; increments each cycle in those states.
  - Timeout fires when the counter equals TIMEOUT-1 and no done is present.
  - On timeout, timeout_err is set; it is cleared only by reset.
- Done pulses that arrive while the matching grant is not held are ignored.
- VGA mux:
  - One-cycle latency: vga_* at cycle n+1 equal the granted drawer's inputs at cycle n.
  - When no grant is held (START, IDLE, UPDATE, DEAD), vga_plot=0 and vga_x/y/colour hold their last values.
  - Plot strobes from non-granted drawers never reach vga_plot.
- Overrun:
  - A frame_tick in any state other than IDLE, START or DEAD is dropped.
  - Each dropped tick increments overrun_count, saturating at 255.
  - frame_tick in START or DEAD is ignored without counting.
- Simultaneous events:
  - Done and timeout in the same cycle: treated as done; timeout_err is not set.
  - Press in a non-START/DEAD state is ignored.
- Reset mid-phase: immediate return to START. gnt drops asynchronously to 000 and vga_plot to 0.

Test Plan:
1. Reset, then go_n 1->0, then frame_tick -> cur_state 0->1->2; gnt=001 one cycle after the tick.
2. In ERASE, drive erase_plot=1, erase_x=8'd37, y=7'd12, colour=3'b101, and bird_plot=1 at the same time -> next cycle vga_plot=1, vga_x=37, y=12, colour=5; bird inputs have no effect.
3. Full frame: erase_done at cycle 10, bird_done 20 cycles after BIRD entry, wall_done with collision=0 -> update_pulse high exactly one cycle between ERASE and BIRD; end in IDLE with gnt=000.
4. wall_done with collision=1 -> DEAD, game_over=1, gnt=000. A later frame_tick has no effect; a press -> IDLE with game_over=0.
5. TIMEOUT=16 and bird_done never arrives -> WALL entered 16 cycles after BIRD entry; timeout_err=1 and stays high through later frames until reset.
6. Pulse frame_tick 300 times during a stalled ERASE phase -> overrun_count saturates at 255. Then assert resetn=0 mid-ERASE -> gnt=000 immediately; cur_state=0 and overrun_count=0.
